// File: rtl/cross_mul_if.sv
// Request/operand/result bundle between the geofence requesters and the shared
// cross-product engine.
interface cross_mul_if #(parameter int W = 11);
  logic                  req0;
  logic signed [W-1:0]   r0_dx1, r0_dy1, r0_dx2, r0_dy2;
  logic                  req1;
  logic signed [W-1:0]   r1_dx1, r1_dy1, r1_dx2, r1_dy2;
  logic                  ack0;
  logic                  ack1;
  logic signed [2*W:0]   result;
  logic                  result_neg;
  logic                  result_zero;
  logic                  busy;
  logic                  owner;

  modport master (
    output req0, r0_dx1, r0_dy1, r0_dx2, r0_dy2,
    output req1, r1_dx1, r1_dy1, r1_dx2, r1_dy2,
    input  ack0, ack1, result, result_neg, result_zero, busy, owner
  );

  modport slave (
    input  req0, r0_dx1, r0_dy1, r0_dx2, r0_dy2,
    input  req1, r1_dx1, r1_dy1, r1_dx2, r1_dy2,
    output ack0, ack1, result, result_neg, result_zero, busy, owner
  );
endinterface

// File: rtl/cross_mul_arbiter.sv
// Round-robin shared radix-2 Booth engine computing dx1*dy2 - dx2*dy1 for two
// requesters; the two products run back-to-back on one serial multiplier.
module cross_mul_arbiter #(
  parameter int W = 11
) (
  input  logic       clk,
  input  logic       reset,
  cross_mul_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_m, r_q, r_dx2, r_dy1;
  logic [W:0]      r_a;
  logic            r_qm1;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_p1;
  logic [2*W:0]    r_result;
  logic            r_last, r_owner, r_ack0, r_ack1, r_busy, r_neg, r_zero;

  logic            w_req_any, w_grant;
  logic [W-1:0]    w_g_dx1, w_g_dy1, w_g_dx2, w_g_dy2;
  logic [W:0]      w_m_ext, w_sum, w_a_sh;
  logic [W-1:0]    w_q_sh;
  logic [2*W-1:0]  w_p_step, w_p_reg;
  logic [2*W:0]    w_res;

  // On a tie the requester that was not served last wins.
  assign w_req_any = bus.req0 | bus.req1;
  assign w_grant   = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_g_dx1   = w_grant ? bus.r1_dx1 : bus.r0_dx1;
  assign w_g_dy1   = w_grant ? bus.r1_dy1 : bus.r0_dy1;
  assign w_g_dx2   = w_grant ? bus.r1_dx2 : bus.r0_dx2;
  assign w_g_dy2   = w_grant ? bus.r1_dy2 : bus.r0_dy2;

  // A carries one guard bit so M = -2^(W-1) subtracts exactly.
  assign w_m_ext = {r_m[W-1], r_m};

  always_comb begin
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + w_m_ext;
      2'b10:   w_sum = r_a - w_m_ext;
      default: w_sum = r_a;
    endcase
  end

  assign w_a_sh   = {w_sum[W], w_sum[W:1]};
  assign w_q_sh   = {w_sum[0], r_q[W-1:1]};
  assign w_p_step = {w_a_sh[W-1:0], w_q_sh};
  assign w_p_reg  = {r_a[W-1:0], r_q};
  assign w_res    = {r_p1[2*W-1], r_p1} - {w_p_reg[2*W-1], w_p_reg};

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req_any) w_next = MUL1;
      MUL1:    if (r_cnt == CW'(W - 1)) w_next = MUL2;
      MUL2:    if (r_cnt == CW'(W)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m      <= '0;
      r_q      <= '0;
      r_a      <= '0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_dx2    <= '0;
      r_dy1    <= '0;
      r_p1     <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_busy   <= 1'b0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_busy <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_owner <= w_grant;
            r_m     <= w_g_dx1;
            r_q     <= w_g_dy2;
            r_dx2   <= w_g_dx2;
            r_dy1   <= w_g_dy1;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        MUL1: begin
          if (r_cnt == CW'(W - 1)) begin
            r_p1  <= w_p_step;
            r_m   <= r_dx2;
            r_q   <= r_dy1;
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
          end else begin
            r_a   <= w_a_sh;
            r_q   <= w_q_sh;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt + CW'(1);
          end
        end
        MUL2: begin
          if (r_cnt == CW'(W)) begin
            r_result <= w_res;
            r_neg    <= w_res[2*W];
            r_zero   <= (w_res == '0);
            r_ack0   <= ~r_owner;
            r_ack1   <= r_owner;
            r_last   <= r_owner;
          end else begin
            r_a   <= w_a_sh;
            r_q   <= w_q_sh;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.result      = r_result;
  assign bus.result_neg  = r_neg;
  assign bus.result_zero = r_zero;
  assign bus.busy        = r_busy;
  assign bus.owner       = r_owner;

endmodule

// File: tb/tb_cross_mul_arbiter.sv
// Self-checking bench for cross_mul_arbiter: directed corner cases plus random
// requests scored against a plain-arithmetic cross-product model.
module tb_cross_mul_arbiter;
  localparam int W   = 11;
  localparam int LAT = 2 * W + 2;   // negedges from req-drive to first sight of ack

  typedef logic signed [W-1:0] op_t;
  typedef logic signed [2*W:0] res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  cross_mul_if #(.W(W)) bus ();

  cross_mul_arbiter #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic longint model_cross(input op_t dx1, dy1, dx2, dy2);
    return longint'(dx1) * longint'(dy2) - longint'(dx2) * longint'(dy1);
  endfunction

  function automatic op_t rnd_op();
    op_t v;
    v = op_t'($urandom_range(0, (1 << W) - 1));
    return v;
  endfunction

  task automatic set_ops(input bit who, input op_t dx1, dy1, dx2, dy2);
    if (!who) begin
      bus.r0_dx1 = dx1; bus.r0_dy1 = dy1; bus.r0_dx2 = dx2; bus.r0_dy2 = dy2;
    end else begin
      bus.r1_dx1 = dx1; bus.r1_dy1 = dy1; bus.r1_dx2 = dx2; bus.r1_dy2 = dy2;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Issues one request from an idle engine; cyc = -1 on timeout.
  task automatic do_request(input bit who, input op_t dx1, dy1, dx2, dy2,
                            output int cyc, output bit saw_other);
    int guard;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    set_ops(who, dx1, dy1, dx2, dy2);
    if (!who) bus.req0 = 1'b1; else bus.req1 = 1'b1;
    cyc = -1;
    saw_other = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if ((who ? bus.ack0 : bus.ack1) === 1'b1) saw_other = 1'b1;
      if ((who ? bus.ack1 : bus.ack0) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  // Runs one request and checks latency, result, flags and owner against the model.
  task automatic run_checked(input string name, input bit who, input op_t dx1, dy1, dx2, dy2);
    int     cyc;
    bit     other;
    longint e;
    res_t   er;
    e  = model_cross(dx1, dy1, dx2, dy2);
    er = res_t'(e);
    do_request(who, dx1, dy1, dx2, dy2, cyc, other);
    n_tests++;
    if (cyc !== LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT);
    end
    n_tests++;
    if (bus.result !== er) begin
      n_fail++;
      $display("FAIL %s result: got %0d want %0d", name, bus.result, er);
    end
    n_tests++;
    if ({bus.result_neg, bus.result_zero} !== {e < 0, e == 0}) begin
      n_fail++;
      $display("FAIL %s flags neg/zero: got %b%b want %b%b", name,
               bus.result_neg, bus.result_zero, e < 0, e == 0);
    end
    n_tests++;
    if (bus.owner !== who || other) begin
      n_fail++;
      $display("FAIL %s owner/other-ack: got owner %b other %b want owner %b other 0",
               name, bus.owner, other, who);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.owner, bus.result_neg, bus.result_zero} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset flags: got %b want 000001",
               {bus.ack0, bus.ack1, bus.busy, bus.owner, bus.result_neg, bus.result_zero});
    end
    n_tests++;
    if (bus.result !== res_t'(0)) begin
      n_fail++;
      $display("FAIL reset result: got %0d want 0", bus.result);
    end
  endtask

  task automatic test_single();
    run_checked("single", 1'b0, 3, 4, 5, -2);
    n_tests++;
    if (bus.result !== res_t'(-26)) begin
      n_fail++;
      $display("FAIL single literal: got %0d want -26", bus.result);
    end
  endtask

  task automatic test_extremes();
    run_checked("extreme_a", 1'b1, -1024, -1024, 1023, -1024);
    n_tests++;
    if (bus.result !== res_t'(2096128)) begin
      n_fail++;
      $display("FAIL extreme_a literal: got %0d want 2096128", bus.result);
    end
    run_checked("extreme_b", 1'b1, -1024, 17, 0, -1024);
    n_tests++;
    if (bus.result !== res_t'(1048576)) begin
      n_fail++;
      $display("FAIL extreme_b literal: got %0d want 1048576", bus.result);
    end
  endtask

  task automatic test_zero();
    run_checked("collinear", 1'b0, 2, 4, 1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_checked($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                  rnd_op(), rnd_op(), rnd_op(), rnd_op());
  endtask

  task automatic test_contention();
    op_t     o0 [4];
    op_t     o1 [4];
    longint  e0, e1;
    int      cyc, last_cyc, n_ack;
    bit      expect_who;
    for (int k = 0; k < 4; k++) begin
      o0[k] = rnd_op();
      o1[k] = rnd_op();
    end
    e0 = model_cross(o0[0], o0[1], o0[2], o0[3]);
    e1 = model_cross(o1[0], o1[1], o1[2], o1[3]);
    @(negedge clk);
    reset = 1'b0;
    set_ops(1'b0, o0[0], o0[1], o0[2], o0[3]);
    set_ops(1'b1, o1[0], o1[1], o1[2], o1[3]);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    n_ack = 0;
    last_cyc = 0;
    expect_who = 1'b0;
    for (cyc = 1; cyc <= 200 && n_ack < 4; cyc++) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL contention both acks high at cycle %0d", cyc);
      end else if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        n_tests++;
        if (bus.ack1 !== expect_who || bus.owner !== expect_who) begin
          n_fail++;
          $display("FAIL contention grant %0d: got ack1 %b owner %b want %b",
                   n_ack, bus.ack1, bus.owner, expect_who);
        end
        n_tests++;
        if (bus.result !== res_t'(expect_who ? e1 : e0)) begin
          n_fail++;
          $display("FAIL contention result %0d: got %0d want %0d",
                   n_ack, bus.result, res_t'(expect_who ? e1 : e0));
        end
        if (n_ack > 0) begin
          n_tests++;
          if (cyc - last_cyc !== 2 * W + 3) begin
            n_fail++;
            $display("FAIL contention spacing %0d: got %0d want %0d",
                     n_ack, cyc - last_cyc, 2 * W + 3);
          end
        end
        last_cyc = cyc;
        expect_who = ~expect_who;
        n_ack++;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    n_tests++;
    if (n_ack !== 4) begin
      n_fail++;
      $display("FAIL contention ack count: got %0d want 4", n_ack);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen_ack;
    set_ops(1'b0, 100, -7, 33, 250);
    bus.req0 = 1'b1;
    repeat (11) @(negedge clk);
    reset = 1'b0;
    bus.req0 = 1'b0;
    #1;
    n_tests++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.owner, bus.result_neg, bus.result_zero} !== 6'b000001
        || bus.result !== res_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got flags %b result %0d want 000001 result 0",
               {bus.ack0, bus.ack1, bus.busy, bus.owner, bus.result_neg, bus.result_zero},
               bus.result);
    end
    seen_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) seen_ack = 1'b1;
    end
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) seen_ack = 1'b1;
    end
    n_tests++;
    if (seen_ack || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid stray activity: got ack %b busy %b want 0 0", seen_ack, bus.busy);
    end
    run_checked("after_reset", 1'b1, -300, 511, 77, -1000);
  endtask

  task automatic test_late_change();
    op_t    a, b, c, d;
    longint e;
    int     cyc;
    a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op();
    e = model_cross(a, b, c, d);
    set_ops(1'b0, a, b, c, d);
    bus.req0 = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == W + 4) begin
        set_ops(1'b0, rnd_op(), rnd_op(), rnd_op(), rnd_op());
        bus.req0 = 1'b0;
      end
      if (bus.ack0 === 1'b1) begin
        cyc = i;
        break;
      end
    end
    n_tests++;
    if (cyc !== LAT) begin
      n_fail++;
      $display("FAIL late_change latency: got %0d want %0d", cyc, LAT);
    end
    n_tests++;
    if (bus.result !== res_t'(e)) begin
      n_fail++;
      $display("FAIL late_change result: got %0d want %0d", bus.result, res_t'(e));
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    set_ops(1'b0, 0, 0, 0, 0);
    set_ops(1'b1, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_extremes();
    test_zero();
    test_random();
    test_contention();
    test_reset_mid();
    test_late_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cross_mul_arbiter.md
Name: cross_mul_arbiter

Overview:
- Shared serial radix-2 Booth engine that computes the 2-D cross product dx1*dy2 - dx2*dy1 for two requesters, e.g. the fence sort unit and the inside-test unit.
- Arbitrates round-robin between the requesters and runs the two multiplies back-to-back on one multiplier.
- Returns the signed result with sign and zero flags.
- Replaces per-FSM multiplier sequencing in the geofence datapath.

Parameters:
- W, 11, signed operand width (coordinate differences); product is 2W bits, result is 2W+1 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 request; held until ack0
- r0_dx1, r0_dy1, r0_dx2, r0_dy2  in  W each  requester 0 signed operands; stable while req0 is high
- req1  in  1  requester 1 request
- r1_dx1, r1_dy1, r1_dx2, r1_dy2  in  W each  requester 1 signed operands
- ack0  out  1  one-cycle pulse; result valid for requester 0
- ack1  out  1  one-cycle pulse; result valid for requester 1
- result  out  2W+1  signed dx1*dy2 - dx2*dy1; held until the next ack
- result_neg  out  1  result < 0
- result_zero  out  1  result == 0
- busy  out  1  engine owned (any state other than IDLE)
- owner  out  1  index of the current or last granted requester

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; ack0 = ack1 = 0; result = 0; result_neg = 0; result_zero = 1; busy = 0; owner = 0.
  - Last-served pointer = 1, so requester 0 wins the first tie.
  - Reset asserted mid-operation aborts it. No ack is issued and the partial product is discarded.
- States: IDLE, MUL1, MUL2, DONE. All outputs are registered.
- IDLE:
  - Samples req0/req1 on each edge.
  - With a single request, that requester is granted.
  - With both requests, the requester that is not the last served is granted.
  - On grant: latch all four operands of the winner and set owner. Load pass 1 with multiplicand = dx1, multiplier Q = dy2, accumulator A = 0, q-1 = 0, iteration counter = 0. Go to MUL1.
- MUL1 / MUL2 Booth step, one per cycle, W cycles per pass:
  - {Q[0], q-1} = 01: A += M. 10: A -= M. 00/11: no add.
  - Then arithmetic right shift of {A, Q, q-1}.
  - A is W+1 bits, sign-extended, so M = -2^(W-1) is exact.
  - Product = low 2W bits of {A, Q} after W steps.
- MUL1 end (counter = W-1): store p1 = product. Reload with M = dx2, Q = dy1, A = 0, counter = 0. Go to MUL2.
- MUL2 end:
  - result <= sext(p1) - sext(p2), at 2W+1 bits; no overflow is possible.
  - Update result_neg and result_zero.
  - Pulse ack of owner; update last-served = owner. Go to DONE.
- DONE: ack high for this cycle only; requests are ignored. Go to IDLE next edge.
- Latency:
  - req sampled at edge E0; ack high in the cycle after edge E0+2W+1, i.e. 23 cycles for W=11.
  - Next grant is no earlier than edge E0+2W+2.
- Requester protocol: the requester drops req on the edge where it samples ack. A req still high in IDLE after DONE is treated as a new request.
- req dropped while owned: operation completes and ack still pulses (protocol violation, tolerated).
- Operand changes while owned: ignored, because operands are latched.
- Only one ack is ever high. The non-owner's req is held pending, with no timeout.

Test Plan:
- Single request: req0, dx1=3, dy1=4, dx2=5, dy2=-2 -> ack0 23 cycles after grant edge, result=-26, result_neg=1, ack1 never.
- Extremes: r1 dx1=-1024, dy2=-1024, dx2=1023, dy1=-1024 -> ack1, result=2096128, result_neg=0. Also dx1=dy2=-1024 with dx2=0 -> 1048576 (checks W+1 accumulator).
- Contention: req0 and req1 both high from reset, held -> grants 0,1,0,1. Each ack comes at 25-cycle spacing, result matches the owner's operands, and owner toggles.
- Zero and collinear: dx1=2, dy1=4, dx2=1, dy2=2 -> result=0, result_zero=1, result_neg=0.
- Reset mid-op: drop reset 10 cycles into MUL1 -> no ack, busy=0, result=0, outputs at reset values. A fresh req1 afterwards completes correctly.
- Late req deassert and operand change: change r0 operands and drop req0 during MUL2 -> ack0 still pulses with the originally latched result.
